// File: rtl/spi_responder.sv
// SPI mode-0 responder: oversamples sclk/cs_n/mosi on raw_clk and exchanges 8- or 16-bit words.
// Optional sticky overrun flag is enabled by defining SPI_RESPONDER_OVERRUN_EN.
module spi_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        raw_clk,
    input  logic        reset_n,
    input  logic        width_16,
    input  logic [15:0] tx_data,
    output logic [15:0] rx_data,
    output logic        rx_valid,
    input  logic        rx_ack,
    output logic        busy,
    output logic        overrun,
    input  logic        sclk,
    input  logic        cs_n,
    input  logic        mosi,
    output logic        miso,
    output logic        miso_oe
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sclk_prev_q, cs_prev_q;
    logic                   width_q, width_d;
    logic [15:0]            tx_shift_q, tx_shift_d;
    logic [15:0]            rx_shift_q, rx_shift_d;
    logic [4:0]             bit_cnt_q, bit_cnt_d;
    logic [15:0]            rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   miso_q, miso_d;
    logic                   miso_oe_q, miso_oe_d;

    logic        sclk_s, cs_s, mosi_s;
    logic        sclk_rise, sclk_fall, cs_fall, cs_rise;
    logic [15:0] tx_load;
    logic [4:0]  last_cnt;

    function automatic logic [15:0] align_tx(input logic w16, input logic [15:0] d);
        return w16 ? d : {d[7:0], 8'h00};
    endfunction

    always_ff @(posedge raw_clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
            cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;
    assign cs_rise   = cs_s & ~cs_prev_q;
    assign tx_load   = align_tx(width_16, tx_data);
    assign last_cnt  = width_q ? 5'd16 : 5'd8;

`ifdef SPI_RESPONDER_OVERRUN_EN
    logic overrun_q, overrun_d;
    always_ff @(posedge raw_clk or negedge reset_n) begin
        if (!reset_n) overrun_q <= 1'b0;
        else          overrun_q <= overrun_d;
    end
    assign overrun = overrun_q;
`else
    assign overrun = 1'b0;
`endif

    always_ff @(posedge raw_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            width_q    <= 1'b0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            bit_cnt_q  <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            miso_q     <= 1'b0;
            miso_oe_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            width_q    <= width_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            miso_q     <= miso_d;
            miso_oe_q  <= miso_oe_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        width_d    = width_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        bit_cnt_d  = bit_cnt_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q & ~rx_ack;
        miso_d     = miso_q;
        miso_oe_d  = miso_oe_q;
`ifdef SPI_RESPONDER_OVERRUN_EN
        overrun_d  = overrun_q & ~rx_ack;
`endif
        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d    = SHIFT;
                    width_d    = width_16;
                    tx_shift_d = tx_load;
                    miso_d     = tx_load[15];
                    bit_cnt_d  = '0;
                    miso_oe_d  = 1'b1;
                end
            end
            SHIFT: begin
                if (sclk_rise) begin
                    rx_shift_d = {rx_shift_q[14:0], mosi_s};
                    bit_cnt_d  = bit_cnt_q + 5'd1;
                    if (bit_cnt_q + 5'd1 == last_cnt) state_d = DONE;
                // count 0 here means the fall trailing the previous word's last bit
                end else if (sclk_fall && bit_cnt_q != 5'd0) begin
                    tx_shift_d = {tx_shift_q[14:0], 1'b0};
                    miso_d     = tx_shift_q[14];
                end
            end
            DONE: begin
                rx_data_d  = width_q ? rx_shift_q : {8'h00, rx_shift_q[7:0]};
                rx_valid_d = 1'b1;
`ifdef SPI_RESPONDER_OVERRUN_EN
                if (rx_valid_q && !rx_ack) overrun_d = 1'b1;
`endif
                bit_cnt_d  = '0;
                if (!cs_s) begin
                    state_d    = SHIFT;
                    width_d    = width_16;
                    tx_shift_d = tx_load;
                    miso_d     = tx_load[15];
                end else begin
                    state_d   = IDLE;
                    miso_d    = 1'b0;
                    miso_oe_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (cs_rise) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            miso_d    = 1'b0;
            miso_oe_d = 1'b0;
        end
    end

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = (state_q != IDLE);
    assign miso     = miso_q;
    assign miso_oe  = miso_oe_q;

endmodule
